i2s_transmitter: RTL

I2S bus master transmitter: generates BCK and LRCK from the system clock and serialises stereo 32-bit sample frames onto SDATA, MSB first, in standard I2S framing (LRCK low = left, data delayed one BCK after each LRCK edge). It sits on the audio output path between the sample source (test pattern / DSP) and an external I2S DAC or the team's I2S receiver block in loopback. A one-frame holding buffer decouples the valid/ready sample interface from the serial frame timing.

---
 rtl/i2s_transmitter.sv | 118 +++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// i2s_transmitter
//   I2S bus master transmitter. Divides clk_i down to BCK, generates LRCK
//   and shifts stereo 32-bit frames out on SDATA, MSB first, standard I2S
//   framing (LRCK low = left, data lags each LRCK edge by one BCK).
//   A one-frame holding buffer sits between the valid/ready sample port
//   and the serial frame timing.
//
//   Optional feature macro: I2S_TX_UNDERRUN_HOLD_EN
//     defined     -> on underrun, resend the last frame that loaded from the buffer
//     not defined -> on underrun, send silence (zeros)
//
// Ports
//   clk_i        system clock
//   rst_ni       async active-low reset
//   data_l_i     left sample (32b)
//   data_r_i     right sample (32b)
//   data_vld_i   frame valid
//   data_rdy_o   holding buffer empty (registered)
//   bck_o        bit clock, period 2*BCK_DIV clk_i
//   lrck_o       word select, 0 = left, 1 = right
//   sdata_o      serial data, changes on BCK falling edges
//   frame_stb_o  one-cycle pulse per frame load
//   underrun_o   one-cycle pulse when a frame load finds the buffer empty
module i2s_transmitter #(
  parameter int BCK_DIV = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] data_l_i,
  input  logic [31:0] data_r_i,
  input  logic        data_vld_i,
  output logic        data_rdy_o,
  output logic        bck_o,
  output logic        lrck_o,
  output logic        sdata_o,
  output logic        frame_stb_o,
  output logic        underrun_o
);

  localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [5:0]    bit_nxt;
  logic [63:0]   shifter;
  logic [63:0]   buf_q;
  logic [63:0]   last_q;
  logic [63:0]   fill;
  logic          div_tc;
  logic          fall;
  logic          load;
  logic          buf_full;
  logic          wr;

  // data_rdy_o is the registered inverse of the buffer-full flag, so the
  // flag itself needs no separate storage.
  assign buf_full = ~data_rdy_o;
  assign wr       = data_vld_i & data_rdy_o;

  assign div_tc  = (div_cnt == DW'(BCK_DIV - 1));
  // Fall cycle: the cycle whose edge drives bck_o 1->0.
  assign fall    = div_tc & bck_o;
  assign bit_nxt = bit_cnt + 6'd1;
  assign load    = fall & (bit_cnt == 6'd63);

  // Underrun fill; last_q is pruned away in the silence build.
  assign fill = HOLD ? last_q : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt     <= '0;
      bck_o       <= 1'b0;
      bit_cnt     <= 6'd63;
      lrck_o      <= 1'b0;
      sdata_o     <= 1'b0;
      shifter     <= '0;
      buf_q       <= '0;
      last_q      <= '0;
      data_rdy_o  <= 1'b1;
      frame_stb_o <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + DW'(1);
      if (div_tc) bck_o <= ~bck_o;

      frame_stb_o <= load;
      underrun_o  <= load & ~buf_full;

      if (fall) begin
        bit_cnt <= bit_nxt;
        lrck_o  <= bit_nxt[5];
        // Shifter MSB goes out first; on the load fall the last bit of the
        // old frame (R[0]) leaves while the new frame drops in behind it.
        sdata_o <= shifter[63];
        if (load) shifter <= buf_full ? buf_q : fill;
        else      shifter <= {shifter[62:0], 1'b0};
      end

      // A load with a full buffer cannot coincide with a write (rdy is low),
      // but a write can coincide with an empty-buffer load: that frame is
      // kept for the following load.
      if (load && buf_full) begin
        data_rdy_o <= 1'b1;
        last_q     <= buf_q;
      end else if (wr) begin
        data_rdy_o <= 1'b0;
        buf_q      <= {data_l_i, data_r_i};
      end
    end
  end

endmodule
